sd_reg_arbiter: RTL and testbench
=================================

// Module: sd_reg_arbiter
// PURPOSE
//  Shares the sdc_controller register port (addr/we/data_in/data_out) between two requesters:
//  m0 = spi_link_sm (host register access), m1 = SD sample-streaming engine.
//  Serialises accesses, holds grant across multi-access sequences via lock, and returns read data.
//  Sits between the requesters and sdc_controller on the SYSCLK domain.
// PARAMETERS
//  ADDR_W        7    register address width (matches sdc_controller addr)
//  DATA_W        8    register data width
//  LOCK_TIMEOUT  255  idle cycles a locked owner may hold the grant before forced release; 0 = never
// PORTS
//  clk           in   1       system clock
//  rst           in   1       synchronous reset, active-high
//  mN_req        in   1       N=0,1: access request, level; hold with fields stable until mN_ack
//  mN_addr       in   ADDR_W  register address
//  mN_we         in   1       1 = write, 0 = read
//  mN_wdata      in   DATA_W  write data
//  mN_lock       in   1       keep grant after this access
//  mN_ack        out  1       one-cycle completion pulse
//  mN_rdata      out  DATA_W  read data, valid while mN_ack=1, held until the next ack to that master
//  sd_addr       out  ADDR_W  to sdc_controller addr
//  sd_we         out  1       to sdc_controller we
//  sd_data_o     out  DATA_W  to sdc_controller data_in
//  sd_data_i     in   DATA_W  from sdc_controller data_out (registered, 1 cycle after addr)
//  owner         out  1       master currently granted (valid when busy=1)
//  busy          out  1       grant held (any state but IDLE)
//  lock_timeout  out  1       one-cycle pulse on forced lock release
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rr_ptr=0 (m0 preferred first); timeout counter 0.
//  States: IDLE -> SETUP -> CAPTURE -> ACK -> {IDLE | HOLD}; HOLD -> SETUP | IDLE.
//  IDLE: arbitrate among asserted req; winner latched as owner; addr/we/wdata/lock latched.
//  SETUP (1 cyc): sd_addr/sd_data_o = latched values; sd_we=latched we (single-cycle pulse).
//  CAPTURE (1 cyc): sd_addr held, sd_we=0; rdata_reg <= sd_data_i at end of cycle (reads and writes).
//  ACK (1 cyc): mN_ack=1 for owner, mN_rdata=rdata_reg; sd_addr held; next: HOLD if latched lock=1 else IDLE.
//  Latency: req seen in IDLE at cycle N -> sd_we at N+1 -> ack at N+3. Back-to-back: new access every 4 cycles.
//  Requester updates/drops req on the edge ending its ack cycle; arbiter never samples req in ACK.
//  HOLD: only owner served. owner req=1 -> SETUP (latch fields, restart). owner req=0 and lock=0 -> IDLE.
//    owner req=0, lock=1: count cycles; at count==LOCK_TIMEOUT -> IDLE, lock_timeout pulse, rr_ptr to other.
//    Counter clears on leaving HOLD. LOCK_TIMEOUT=0 disables the timeout.
//  Simultaneous req in IDLE: see CONFIGURATION; non-winner waits, no ack, no data loss.
//  Outside SETUP..ACK: sd_addr=0, sd_data_o=0, sd_we=0.
//  mN_we/addr changes while waiting (not granted) are permitted; values latched at grant.
//  Reset mid-operation: immediate return to IDLE on next edge; sd_we and acks forced 0; no ack issued.
// CONFIGURATION
//  SD_ARB_ROUND_ROBIN_EN defined: simultaneous req -> grant master != last winner (rr_ptr);
//    rr_ptr flips after each completed grant tenure (IDLE re-entry).
//  Undefined: fixed priority, m0 always wins in IDLE; rr_ptr unused; HOLD/lock unchanged.
// TESTING
//  T1 m0 write addr=0x05 data=0xA3 -> sd_we=1 one cycle at N+1, sd_addr=0x05, sd_data_o=0xA3; m0_ack at N+3.
//  T2 sd_data_i model returns 0x5C for addr 0x10; m1 read 0x10 -> m1_ack at N+3, m1_rdata=0x5C.
//  T3 RR_EN: m0,m1 req continuously -> grant order m0,m1,m0,m1; RR off -> m0 only, m1 starved.
//  T4 m1 lock=1 for 3 writes while m0 req -> 3 m1 acks back-to-back (4 cyc apart), then m0 granted.
//  T5 LOCK_TIMEOUT=4, m1 lock=1 then req=0 -> lock_timeout pulse 4 cycles in HOLD, busy=0, m0 granted next.
//  T6 rst in CAPTURE of m0 write -> no m0_ack, all outputs 0 next cycle; m0 req retry completes normally.

Source files
------------

// File: rtl/sd_reg_arbiter.sv
// sd_reg_arbiter
//   Shares the sdc_controller register port between two requesters on the SYSCLK domain:
//   m0 = spi_link_sm (host register access), m1 = SD sample-streaming engine.
//   Each access runs IDLE -> SETUP -> CAPTURE -> ACK, then returns to IDLE, or parks in HOLD
//   when the requester asked for the lock. From HOLD only the owner can start another access.
//   A locked owner that sits idle in HOLD is released after LOCK_TIMEOUT cycles. The
//   lock_timeout pulse is raised in the last HOLD cycle. LOCK_TIMEOUT = 0 never releases.
//
//   Build option: define SD_ARB_ROUND_ROBIN_EN to break ties in IDLE round-robin. The master
//   that did not win the last tenure is preferred. Without the macro, m0 always wins a tie.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   mN_req/addr/we/wdata   level request plus access fields; hold them stable until mN_ack
//   mN_lock                keep the grant after this access
//   mN_ack                 one-cycle completion pulse
//   mN_rdata               captured read data; valid with mN_ack, held until the next mN_ack
//   sd_addr/sd_we/sd_data_o  drive sdc_controller; zero outside SETUP..ACK
//   sd_data_i              sdc_controller data_out, registered one cycle after addr
//   owner, busy            granted master, and whether a grant is held (state != IDLE)
//   lock_timeout           one-cycle pulse on a forced lock release
module sd_reg_arbiter #(
   parameter int unsigned ADDR_W       = 7,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned LOCK_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_we,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m0_lock,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m1_we,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_lock,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] sd_addr,
   output logic              sd_we,
   output logic [DATA_W-1:0] sd_data_o,
   input  logic [DATA_W-1:0] sd_data_i,
   output logic              owner,
   output logic              busy,
   output logic              lock_timeout
);

   typedef enum logic [2:0] {StIdle, StSetup, StCapture, StAck, StHold} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              lock_q, lock_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
   logic [31:0]       cnt_q, cnt_d;

   logic              grant;     // IDLE winner
   logic              sel;       // master whose fields are latched on entry to SETUP
   logic              own_req;
   logic              own_lock;
   logic              in_xfer;

`ifdef SD_ARB_ROUND_ROBIN_EN
   logic              rr_ptr_q, rr_ptr_d;

   // A tie goes to rr_ptr. A lone requester always wins.
   assign grant = (m0_req && m1_req) ? rr_ptr_q : !m0_req;

   // On every return to IDLE, prefer the master that did not hold this tenure.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q != StIdle && state_d == StIdle) begin
         rr_ptr_d = !owner_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   assign grant = !m0_req;
`endif

   assign sel      = (state_q == StIdle) ? grant : owner_q;
   assign own_req  = owner_q ? m1_req : m0_req;
   assign own_lock = owner_q ? m1_lock : m0_lock;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      lock_d       = lock_q;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      cnt_d        = '0;
      lock_timeout = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (m0_req || m1_req) begin
               state_d = StSetup;
               owner_d = grant;
            end
         end
         StSetup:   state_d = StCapture;
         StCapture: begin
            // Capture into the owner's register so the other master's data stays held.
            state_d = StAck;
            if (owner_q) begin
               m1_rdata_d = sd_data_i;
            end else begin
               m0_rdata_d = sd_data_i;
            end
         end
         StAck:     state_d = lock_q ? StHold : StIdle;
         StHold: begin
            if (own_req) begin
               state_d = StSetup;
            end else if (!own_lock) begin
               state_d = StIdle;
            end else if (LOCK_TIMEOUT != 0) begin
               if ((cnt_q + 32'd1) == LOCK_TIMEOUT) begin
                  state_d      = StIdle;
                  lock_timeout = 1'b1;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
         end
         default:   state_d = StIdle;
      endcase

      // The request fields are latched whenever a new access starts, from IDLE or from HOLD.
      if (state_d == StSetup && state_q != StSetup) begin
         addr_d  = sel ? m1_addr  : m0_addr;
         we_d    = sel ? m1_we    : m0_we;
         wdata_d = sel ? m1_wdata : m0_wdata;
         lock_d  = sel ? m1_lock  : m0_lock;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         owner_q    <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         lock_q     <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         lock_q     <= lock_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      in_xfer   = (state_q == StSetup) || (state_q == StCapture) || (state_q == StAck);
      sd_addr   = in_xfer ? addr_q : '0;
      sd_data_o = in_xfer ? wdata_q : '0;
      sd_we     = (state_q == StSetup) && we_q;
      m0_ack    = (state_q == StAck) && !owner_q;
      m1_ack    = (state_q == StAck) && owner_q;
      m0_rdata  = m0_rdata_q;
      m1_rdata  = m1_rdata_q;
      owner     = owner_q;
      busy      = (state_q != StIdle);
   end

endmodule

// File: tb/tb_sd_reg_arbiter.sv
// Directed bench for sd_reg_arbiter with LOCK_TIMEOUT = 4. Two small requester models present
// queued accesses. A register-file model stands in for sdc_controller. The expected
// acknowledgements, in grant order, are kept in a scoreboard queue.
module tb_sd_reg_arbiter;

   logic       clk;
   logic       rst;
   logic       m0_req, m0_we, m0_lock, m0_ack;
   logic [6:0] m0_addr;
   logic [7:0] m0_wdata, m0_rdata;
   logic       m1_req, m1_we, m1_lock, m1_ack;
   logic [6:0] m1_addr;
   logic [7:0] m1_wdata, m1_rdata;
   logic [6:0] sd_addr;
   logic       sd_we;
   logic [7:0] sd_data_o, sd_data_i;
   logic       owner, busy, lock_timeout;

   sd_reg_arbiter #(
      .ADDR_W       (7),
      .DATA_W       (8),
      .LOCK_TIMEOUT (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .m0_req       (m0_req),
      .m0_addr      (m0_addr),
      .m0_we        (m0_we),
      .m0_wdata     (m0_wdata),
      .m0_lock      (m0_lock),
      .m0_ack       (m0_ack),
      .m0_rdata     (m0_rdata),
      .m1_req       (m1_req),
      .m1_addr      (m1_addr),
      .m1_we        (m1_we),
      .m1_wdata     (m1_wdata),
      .m1_lock      (m1_lock),
      .m1_ack       (m1_ack),
      .m1_rdata     (m1_rdata),
      .sd_addr      (sd_addr),
      .sd_we        (sd_we),
      .sd_data_o    (sd_data_o),
      .sd_data_i    (sd_data_i),
      .owner        (owner),
      .busy         (busy),
      .lock_timeout (lock_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // sdc_controller stand-in: registered read of the addressed register, write on sd_we.
   logic       mem_init;
   logic [7:0] mem [128];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h4C;
         sd_data_i <= '0;
      end else begin
         if (sd_we) mem[sd_addr] <= sd_data_o;
         sd_data_i <= mem[sd_addr];
      end
   end

   typedef struct packed {
      logic [6:0] addr;
      logic       we;
      logic [7:0] wdata;
      logic       lock;
   } txn_t;

   typedef struct packed {
      logic       m;
      logic [7:0] rdata;
   } exp_t;

   txn_t pend0[$];
   txn_t pend1[$];
   exp_t sb[$];
   int   ack_cyc[$];
   logic [7:0] ref_mem [128];
   logic idle_lock1;
   int   cyc;
   int   n_assert;
   int   n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference register file. An access returns the value held before the access.
   function automatic logic [7:0] exp_rd(input logic [6:0] a, input logic we, input logic [7:0] wd);
      logic [7:0] r;
      r = ref_mem[a];
      if (we) ref_mem[a] = wd;
      return r;
   endfunction

   // Queue an access for master m. Call in the order the grants are expected.
   task automatic add(input logic m, input logic [6:0] a, input logic we, input logic [7:0] wd,
                      input logic lk);
      txn_t t;
      exp_t e;
      t = '{addr: a, we: we, wdata: wd, lock: lk};
      e = '{m: m, rdata: exp_rd(a, we, wd)};
      if (m) pend1.push_back(t);
      else   pend0.push_back(t);
      sb.push_back(e);
   endtask

   task automatic present();
      if (pend0.size() > 0) begin
         m0_req = 1'b1; m0_addr = pend0[0].addr; m0_we = pend0[0].we;
         m0_wdata = pend0[0].wdata; m0_lock = pend0[0].lock;
      end else begin
         m0_req = 1'b0; m0_lock = 1'b0;
      end
      if (pend1.size() > 0) begin
         m1_req = 1'b1; m1_addr = pend1[0].addr; m1_we = pend1[0].we;
         m1_wdata = pend1[0].wdata; m1_lock = pend1[0].lock;
      end else begin
         m1_req = 1'b0; m1_lock = idle_lock1;
      end
   endtask

   // Advance to the next falling edge. Score any ack there, then let the acked requester move on.
   task automatic cycle();
      exp_t e;
      logic am;
      @(negedge clk);
      cyc++;
      if (m0_ack || m1_ack) begin
         am = m1_ack;
         chk("ack_onehot", 32'(m0_ack & m1_ack), 32'd0);
         if (sb.size() == 0) begin
            chk("ack_unexpected", 32'({m1_ack, m0_ack}), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("ack_master", 32'(am), 32'(e.m));
            chk("ack_rdata", 32'(am ? m1_rdata : m0_rdata), 32'(e.rdata));
         end
         ack_cyc.push_back(cyc);
         if (am && pend1.size() > 0) void'(pend1.pop_front());
         if (!am && pend0.size() > 0) void'(pend0.pop_front());
         present();
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (sb.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_sd_we"}, 32'(sd_we), 32'd0);
      chk({tag, "_sd_addr"}, 32'(sd_addr), 32'd0);
      chk({tag, "_sd_data_o"}, 32'(sd_data_o), 32'd0);
      chk({tag, "_acks"}, 32'({m1_ack, m0_ack}), 32'd0);
      chk({tag, "_m0_rdata"}, 32'(m0_rdata), 32'd0);
      chk({tag, "_m1_rdata"}, 32'(m1_rdata), 32'd0);
      chk({tag, "_busy_owner"}, 32'({busy, owner}), 32'd0);
      chk({tag, "_lock_timeout"}, 32'(lock_timeout), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_assert = 0; n_fail = 0; cyc = 0; idle_lock1 = 1'b0;
      rst = 1'b1; mem_init = 1'b1;
      m0_req = 0; m0_addr = '0; m0_we = 0; m0_wdata = '0; m0_lock = 0;
      m1_req = 0; m1_addr = '0; m1_we = 0; m1_wdata = '0; m1_lock = 0;
      for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i) ^ 8'h4C;
      cycle();
      cycle();
      check_quiet("reset");
      rst = 1'b0; mem_init = 1'b0;
      cycle();

      // T1: m0 write 0x05 <- 0xA3.
      add(1'b0, 7'h05, 1'b1, 8'hA3, 1'b0);
      present();
      cycle();
      chk("t1_sd_we", 32'(sd_we), 32'd1);
      chk("t1_sd_addr", 32'(sd_addr), 32'h05);
      chk("t1_sd_data_o", 32'(sd_data_o), 32'hA3);
      chk("t1_busy_owner", 32'({busy, owner}), 32'b10);
      cycle();
      chk("t1_capture_we", 32'(sd_we), 32'd0);
      chk("t1_capture_addr", 32'(sd_addr), 32'h05);
      cycle();
      chk("t1_ack_n3", 32'(m0_ack), 32'd1);
      cycle();
      chk("t1_after_ack", 32'({busy, m0_ack, sd_addr}), 32'd0);

      // T2: m1 reads 0x10; the register model holds 0x5C there.
      add(1'b1, 7'h10, 1'b0, 8'h00, 1'b0);
      present();
      cycle();
      chk("t2_sd_we", 32'(sd_we), 32'd0);
      cycle();
      cycle();
      chk("t2_ack_n3", 32'(m1_ack), 32'd1);
      chk("t2_rdata", 32'(m1_rdata), 32'h5C);
      cycle();
      chk("t2_rdata_held", 32'(m1_rdata), 32'h5C);
      chk("t2_m0_rdata_kept", 32'(m0_rdata), 32'h49);

      // Reset clears rdata and the round-robin pointer ahead of T3.
      rst = 1'b1;
      cycle();
      check_quiet("reset2");
      rst = 1'b0;

      // T3: both masters request continuously.
`ifdef SD_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 3; i++) begin
         add(1'b0, 7'(8'h20 + i), 1'b1, 8'(8'h30 + i), 1'b0);
         add(1'b1, 7'(8'h28 + i), 1'b0, 8'h00, 1'b0);
      end
`else
      for (int i = 0; i < 3; i++) add(1'b0, 7'(8'h20 + i), 1'b1, 8'(8'h30 + i), 1'b0);
      for (int i = 0; i < 3; i++) add(1'b1, 7'(8'h28 + i), 1'b0, 8'h00, 1'b0);
`endif
      present();
      drain("t3_drain", 60);
      cycle();

      // T4: m1 keeps the lock across three writes while m0 waits.
      ack_cyc.delete();
      add(1'b1, 7'h40, 1'b1, 8'h11, 1'b1);
      add(1'b1, 7'h41, 1'b1, 8'h12, 1'b1);
      add(1'b1, 7'h42, 1'b1, 8'h13, 1'b1);
      present();
      cycle();
      add(1'b0, 7'h50, 1'b0, 8'h00, 1'b0);
      present();
      drain("t4_drain", 60);
      chk("t4_ack_count", 32'(ack_cyc.size()), 32'd4);
      if (ack_cyc.size() == 4) begin
         chk("t4_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd4);
         chk("t4_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd4);
         chk("t4_m0_after_release", 32'(ack_cyc[3] - ack_cyc[2]), 32'd5);
      end
      cycle();

      // T5: m1 holds the lock with no request; it is released after 4 HOLD cycles.
      idle_lock1 = 1'b1;
      add(1'b1, 7'h60, 1'b1, 8'h77, 1'b1);
      present();
      cycle();
      add(1'b0, 7'h61, 1'b0, 8'h00, 1'b0);
      present();
      cycle();
      cycle();
      chk("t5_m1_ack", 32'(m1_ack), 32'd1);
      cycle();
      chk("t5_hold1", 32'({busy, owner, lock_timeout}), 32'b110);
      cycle();
      chk("t5_hold2", 32'(lock_timeout), 32'd0);
      cycle();
      chk("t5_hold3", 32'(lock_timeout), 32'd0);
      cycle();
      chk("t5_timeout_pulse", 32'({busy, lock_timeout}), 32'b11);
      cycle();
      chk("t5_released", 32'({busy, lock_timeout}), 32'b00);
      cycle();
      chk("t5_m0_granted", 32'({busy, owner}), 32'b10);
      idle_lock1 = 1'b0;
      present();
      drain("t5_drain", 20);
      cycle();

      // T6: reset during CAPTURE of an m0 write. The aborted SETUP already wrote the register,
      // so the retry returns the new value.
      void'(exp_rd(7'h70, 1'b1, 8'hC4));
      add(1'b0, 7'h70, 1'b1, 8'hC4, 1'b0);
      present();
      cycle();
      chk("t6_setup_we", 32'(sd_we), 32'd1);
      cycle();
      chk("t6_capture", 32'({busy, sd_we}), 32'b10);
      rst = 1'b1;
      cycle();
      check_quiet("t6_reset");
      rst = 1'b0;
      drain("t6_retry", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
